// File: rtl/fft_sequencer.sv
// Butterfly/stage sequencer for an iterative radix-2 FFT core.
// Issues per-butterfly and per-stage strobes plus a done pulse at the end of a pass.
module fft_sequencer #(
    parameter int LOG2N       = 5,
    parameter int BFLY_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             abort,
    output logic             iteration_strobe,
    output logic             stage_strobe,
    output logic [2:0]       stage_count,
    output logic [LOG2N-2:0] bfly_index,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | executing butterflies of the current stage
    // GAP   | idle cycles between stages
    // DONE  | one-cycle done pulse, then back to IDLE
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0]       BFLY_LAST  = 4'(BFLY_CYCLES - 1);
    localparam logic [3:0]       GAP_LAST   = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [2:0]       STAGE_LAST = 3'(LOG2N - 1);
    localparam logic [LOG2N-2:0] IDX_LAST   = '1;

    logic [1:0] state;
    logic [3:0] cycle_cnt;
    logic [3:0] gap_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            cycle_cnt        <= '0;
            gap_cnt          <= '0;
            bfly_index       <= '0;
            stage_count      <= '0;
            iteration_strobe <= 1'b0;
            stage_strobe     <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            iteration_strobe <= 1'b0;
            stage_strobe     <= 1'b0;
            done             <= 1'b0;
            if (abort) begin
                state       <= S_IDLE;
                cycle_cnt   <= '0;
                gap_cnt     <= '0;
                bfly_index  <= '0;
                stage_count <= '0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state       <= S_RUN;
                            cycle_cnt   <= '0;
                            bfly_index  <= '0;
                            stage_count <= '0;
                            busy        <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (!stall) begin
                            if (cycle_cnt == BFLY_LAST) begin
                                cycle_cnt        <= '0;
                                bfly_index       <= bfly_index + 1'b1;
                                iteration_strobe <= 1'b1;
                                if (bfly_index == IDX_LAST) begin
                                    stage_strobe <= 1'b1;
                                    if (stage_count < STAGE_LAST) begin
                                        stage_count <= stage_count + 3'd1;
                                        gap_cnt     <= '0;
                                        if (GAP_CYCLES != 0)
                                            state <= S_GAP;
                                    end else begin
                                        state <= S_DONE;
                                        busy  <= 1'b0;
                                    end
                                end
                            end else begin
                                cycle_cnt <= cycle_cnt + 4'd1;
                            end
                        end
                    end
                    S_GAP: begin
                        if (!stall) begin
                            if (gap_cnt == GAP_LAST) begin
                                gap_cnt <= '0;
                                state   <= S_RUN;
                            end else begin
                                gap_cnt <= gap_cnt + 4'd1;
                            end
                        end
                    end
                    default: begin
                        // DONE is not stallable: the pulse always lasts one cycle
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fft_sequencer.sv
// Scoreboard bench for fft_sequencer: an event-schedule model predicts every strobe/done,
// a negedge monitor pops and compares whenever the DUT raises one.
module tb_fft_sequencer;

    localparam int LOG2N = 5;
    localparam int BC    = 4;
    localparam int GC    = 2;
    localparam int NB    = 1 << (LOG2N - 1);
    localparam int TOTAL = LOG2N * NB;

    typedef struct {
        int   edge_no;
        bit   it;
        bit   st;
        bit   dn;
        int   sc;
        int   bi;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, stall = 1'b0, abort = 1'b0;
    logic iteration_strobe, stage_strobe, busy, done;
    logic [2:0] stage_count;
    logic [LOG2N-2:0] bfly_index;

    logic start0 = 1'b0;
    logic it0, st0, busy0, done0;
    logic [2:0] sc0;
    logic [LOG2N-2:0] bi0;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;
    ev_t sb[$];
    bit stall_rel[0:699];
    bit prev_strobe = 1'b0;
    int it0_cnt = 0, st0_cnt = 0, it0_last = 0;

    fft_sequencer #(.LOG2N(LOG2N), .BFLY_CYCLES(BC), .GAP_CYCLES(GC)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .abort(abort),
        .iteration_strobe(iteration_strobe), .stage_strobe(stage_strobe),
        .stage_count(stage_count), .bfly_index(bfly_index), .busy(busy), .done(done)
    );

    fft_sequencer #(.LOG2N(LOG2N), .BFLY_CYCLES(BC), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .stall(1'b0), .abort(1'b0),
        .iteration_strobe(it0), .stage_strobe(st0),
        .stage_count(sc0), .bfly_index(bi0), .busy(busy0), .done(done0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n++;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Effective (non-stalled) edge count at which event j completes; j==TOTAL is done.
    function automatic int target(input int j);
        if (j < TOTAL) return BC * (j + 1) + GC * (j / NB);
        return BC * TOTAL + GC * (LOG2N - 1) + 1;
    endfunction

    task automatic plan(input int e0, input int cut, output int done_k);
        int eff = 0;
        int j = 0;
        ev_t e;
        done_k = 0;
        for (int k = 1; k < 700 && j <= TOTAL; k++) begin
            if (!stall_rel[k]) eff++;
            if (eff == target(j)) begin
                e.edge_no = e0 + k;
                e.it = (j < TOTAL);
                e.dn = (j == TOTAL);
                e.st = (j < TOTAL) && (j % NB == NB - 1);
                e.sc = (j < TOTAL) ? j / NB : LOG2N - 1;
                if (e.st && e.sc < LOG2N - 1) e.sc = e.sc + 1;
                e.bi = (j < TOTAL) ? (j + 1) % NB : 0;
                if (e.dn) done_k = k;
                if (e.edge_no < cut) sb.push_back(e);
                j++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_strobe = 1'b0;
        end else begin
            if (iteration_strobe || stage_strobe || done) begin
                ev_t e;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: edge %0d it=%0b st=%0b dn=%0b, expected none",
                             edge_n, iteration_strobe, stage_strobe, done);
                end else begin
                    e = sb.pop_front();
                    if (e.edge_no != edge_n || e.it != iteration_strobe || e.st != stage_strobe ||
                        e.dn != done || e.sc != int'(stage_count) || e.bi != int'(bfly_index)) begin
                        n_fail++;
                        $display("FAIL event: got edge=%0d it=%0b st=%0b dn=%0b sc=%0d bi=%0d expected edge=%0d it=%0b st=%0b dn=%0b sc=%0d bi=%0d",
                                 edge_n, iteration_strobe, stage_strobe, done, stage_count, bfly_index,
                                 e.edge_no, e.it, e.st, e.dn, e.sc, e.bi);
                    end
                end
                if (iteration_strobe || stage_strobe) begin
                    n_checks++;
                    if (prev_strobe) begin
                        n_fail++;
                        $display("FAIL consecutive_strobe: got strobe on edge %0d after strobe, expected gap", edge_n);
                    end
                end
            end
            prev_strobe = iteration_strobe || stage_strobe;
            if (it0) begin it0_cnt++; it0_last = edge_n; end
            if (st0) st0_cnt++;
        end
    end

    // mode: 0 full pass, 1 abort at stage 3 butterfly 7 completion, 2 reset during first GAP
    task automatic run_pass(input int mode, input bit rnd_start);
        int e0, done_k, cut, len;
        @(negedge clk);
        e0  = edge_n + 1;
        cut = (mode == 1) ? e0 + target(3 * NB + 7) : (mode == 2) ? e0 + target(NB - 1) : 1 << 30;
        plan(e0, cut, done_k);
        start = 1'b1;
        len = (mode == 1) ? target(3 * NB + 7) : (mode == 2) ? target(NB - 1) : done_k + 6;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            start = rnd_start && (k < done_k) && ($urandom_range(0, 7) == 0);
            stall = stall_rel[k];
            abort = (mode == 1) && (k == len);
        end
        if (mode == 1) begin
            @(negedge clk);
            abort = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_stage", stage_count, 0);
            chk("abort_bfly", bfly_index, 0);
            chk("abort_done", done, 0);
            repeat (360) @(negedge clk);
        end else if (mode == 2) begin
            @(posedge clk);
            #2 reset = 1'b1;
            #1;
            chk("rst_async_busy", busy, 0);
            chk("rst_async_it", iteration_strobe, 0);
            chk("rst_async_st", stage_strobe, 0);
            chk("rst_async_stage", stage_count, 0);
            repeat (3) @(negedge clk);
            reset = 1'b0;
            repeat (50) @(negedge clk);
            chk("rst_idle_busy", busy, 0);
            chk("rst_idle_stage", stage_count, 0);
        end else begin
            chk("pass_busy_after", busy, 0);
            chk("pass_stage_after", stage_count, LOG2N - 1);
        end
        chk("scoreboard_drained", sb.size(), 0);
        sb.delete();
        for (int k = 0; k < 700; k++) stall_rel[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 700; k++) stall_rel[k] = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_stage", stage_count, 0);
        chk("reset_bfly", bfly_index, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_release_busy", busy, 0);

        run_pass(0, 1'b0);
        for (int k = 140; k < 150; k++) stall_rel[k] = 1'b1;
        run_pass(0, 1'b1);
        for (int p = 0; p < 2; p++) begin
            for (int k = 5; k <= 280; k++) stall_rel[k] = ($urandom_range(0, 5) == 0);
            run_pass(0, 1'b1);
        end
        run_pass(1, 1'b0);
        run_pass(2, 1'b0);

        begin
            int e0;
            @(negedge clk);
            e0 = edge_n + 1;
            it0_cnt = 0; st0_cnt = 0;
            start0 = 1'b1;
            @(negedge clk);
            start0 = 1'b0;
            repeat (340) @(negedge clk);
            chk("gap0_iter_count", it0_cnt, TOTAL);
            chk("gap0_stage_count", st0_cnt, LOG2N);
            chk("gap0_last_strobe_edge", it0_last - e0, BC * TOTAL);
            chk("gap0_busy_after", busy0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_sequencer.md
FFT_SEQUENCER -- requirements
Module: fft_sequencer

Interface
REQ-001 Parameter LOG2N, default 5: log2 of FFT points; 2**(LOG2N-1) butterflies per stage, LOG2N stages.
REQ-002 Parameter BFLY_CYCLES, default 4: clock cycles per butterfly, legal range 1..15.
REQ-003 Parameter GAP_CYCLES, default 2: idle cycles between stages, legal range 0..15.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request a full FFT pass; sampled only in IDLE.
REQ-007 stall  input  1  freezes sequencing for the cycle while high.
REQ-008 abort  input  1  terminates the current pass.
REQ-009 iteration_strobe  output  1  one-cycle pulse per completed butterfly; feeds the downstream iteration counter.
REQ-010 stage_strobe  output  1  one-cycle pulse per completed stage.
REQ-011 stage_count  output  3  current stage index, 0..LOG2N-1.
REQ-012 bfly_index  output  LOG2N-1  butterfly index within the current stage.
REQ-013 busy  output  1  high in RUN and GAP.
REQ-014 done  output  1  one-cycle pulse at the end of a full pass.

Function
REQ-015 States: IDLE, RUN, GAP, DONE; all outputs registered.
REQ-016 IDLE with start=1 at an edge SHALL enter RUN, clearing cycle_cnt, bfly_index and stage_count to 0.
REQ-017 In RUN, each edge with stall=0 SHALL increment cycle_cnt; with stall=1, all counters and the state SHALL hold.
REQ-018 When cycle_cnt==BFLY_CYCLES-1 and stall=0, the edge SHALL zero cycle_cnt, increment bfly_index (wrap to 0) and raise iteration_strobe for exactly the following cycle.
REQ-019 When that butterfly is the last of the stage (bfly_index==2**(LOG2N-1)-1), stage_strobe SHALL pulse in the same cycle as iteration_strobe.
REQ-020 On that last-butterfly edge:
- If stage_count<LOG2N-1: increment stage_count; go to GAP, or directly to RUN if GAP_CYCLES==0.
- Otherwise: go to DONE with stage_count held.
REQ-021 GAP SHALL last GAP_CYCLES non-stalled cycles, then return to RUN; stall holds the GAP counter.
REQ-022 DONE SHALL assert done for one cycle, deassert busy, then go to IDLE unconditionally.
REQ-023 start SHALL be ignored in RUN, GAP and DONE.
REQ-024 abort=1 in any state SHALL force IDLE at the next edge, clear all counters, and suppress strobes and done in the following cycle.
- abort has priority over stall and over strobe generation.
REQ-025 Strobes SHALL never be high for two consecutive cycles when BFLY_CYCLES>1.
REQ-026 A full unstalled pass SHALL produce exactly LOG2N*2**(LOG2N-1) iteration_strobes, LOG2N stage_strobes and one done pulse.

Reset
REQ-027 While reset is high, the block SHALL be in IDLE with all outputs and counters 0, independent of clk.
REQ-028 Reset deassertion SHALL take effect at the first clk edge after release; no strobe SHALL be generated by the reset release itself.

Verification (defaults LOG2N=5, BFLY_CYCLES=4, GAP_CYCLES=2)
REQ-029 Full pass: start pulse at edge E0, stall=0 throughout ->
- first iteration_strobe in the cycle after E4;
- 80 iteration_strobes and 5 stage_strobes in total;
- stage_count steps 0..4;
- done pulses exactly once, 329 cycles after E0;
- busy low afterwards.
REQ-030 Stall: hold stall=1 for 10 cycles mid-butterfly in stage 2 -> every subsequent strobe, and done, is delayed by exactly 10 cycles; counts are unchanged.
REQ-031 Abort: assert abort during stage 3, butterfly 7 -> next cycle state is IDLE, busy=0, stage_count=0, bfly_index=0, and no further strobes or done occur.
REQ-032 Start while busy: pulse start during RUN -> no effect on counters or strobe timing.
REQ-033 Reset mid-pass: assert reset asynchronously between edges during GAP -> outputs go to 0 immediately; after release, the block stays in IDLE until start.
REQ-034 GAP_CYCLES=0 build: stage_strobe is followed by the first butterfly of the next stage with no idle cycles; 80 strobes complete in 320 cycles after start.
